// File: rtl/hotel_pkg.sv
// Shared definitions for the hotel booking/checkout slice: note codes, values, checkout states.
package hotel_pkg;

    localparam logic [2:0] NOTE_NONE = 3'd0;
    localparam logic [2:0] NOTE_10   = 3'd1;
    localparam logic [2:0] NOTE_20   = 3'd2;
    localparam logic [2:0] NOTE_50   = 3'd3;
    localparam logic [2:0] NOTE_100  = 3'd4;
    localparam logic [2:0] NOTE_200  = 3'd5;
    localparam logic [2:0] NOTE_500  = 3'd6;

    localparam int unsigned NOTE_VAL_W = 10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_CHANGE,
        ST_REFUND,
        ST_RECEIPT
    } checkout_state_t;

    // Face value of a note code; 0 for the unused codes 0 and 7.
    function automatic logic [NOTE_VAL_W-1:0] note_value(input logic [2:0] code);
        case (code)
            NOTE_10:  note_value = 10'd10;
            NOTE_20:  note_value = 10'd20;
            NOTE_50:  note_value = 10'd50;
            NOTE_100: note_value = 10'd100;
            NOTE_200: note_value = 10'd200;
            NOTE_500: note_value = 10'd500;
            default:  note_value = 10'd0;
        endcase
    endfunction

endpackage

// File: rtl/note_dispenser.sv
// Greedy note dispenser: after load, emits one largest-fitting note per cycle, then done + residue.
module note_dispenser
    import hotel_pkg::*;
#(
    parameter int unsigned BILL_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [BILL_W-1:0] amount,
    output logic              note_valid,
    output logic [2:0]        note_code,
    output logic              done,
    output logic [3:0]        residue
);

    logic              active;
    logic [BILL_W-1:0] remaining;
    logic [2:0]        pick_code;

    // Largest note that still fits in the remaining amount.
    always_comb begin
        pick_code = NOTE_NONE;
        if (remaining >= BILL_W'(500))      pick_code = NOTE_500;
        else if (remaining >= BILL_W'(200)) pick_code = NOTE_200;
        else if (remaining >= BILL_W'(100)) pick_code = NOTE_100;
        else if (remaining >= BILL_W'(50))  pick_code = NOTE_50;
        else if (remaining >= BILL_W'(20))  pick_code = NOTE_20;
        else if (remaining >= BILL_W'(10))  pick_code = NOTE_10;
    end

    // Dispense sequencer; done pulses once the remainder drops below the smallest note.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active     <= 1'b0;
            remaining  <= '0;
            note_valid <= 1'b0;
            note_code  <= NOTE_NONE;
            done       <= 1'b0;
            residue    <= 4'd0;
        end else begin
            note_valid <= 1'b0;
            note_code  <= NOTE_NONE;
            done       <= 1'b0;
            if (load) begin
                active    <= 1'b1;
                remaining <= amount;
            end else if (active) begin
                if (pick_code != NOTE_NONE) begin
                    note_valid <= 1'b1;
                    note_code  <= pick_code;
                    remaining  <= remaining - BILL_W'(note_value(pick_code));
                end else begin
                    active  <= 1'b0;
                    done    <= 1'b1;
                    residue <= remaining[3:0];
                end
            end
        end
    end

endmodule

// File: rtl/booking_checkout.sv
// Checkout stage: captures a booking, collects notes, dispenses change or refund, issues receipt.
module booking_checkout
    import hotel_pkg::*;
#(
    parameter int unsigned BILL_W         = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              booking_valid,
    input  logic [BILL_W-1:0] bill,
    input  logic [2:0]        room_id,
    input  logic              pay_valid,
    input  logic [2:0]        pay_code,
    input  logic              cancel,
    output logic              busy,
    output logic              booking_reject,
    output logic              pay_reject,
    output logic [BILL_W-1:0] paid_total,
    output logic              note_valid,
    output logic [2:0]        note_code,
    output logic              refund_flag,
    output logic              receipt_valid,
    output logic [2:0]        receipt_room,
    output logic [3:0]        change_residue,
    output logic              timeout_err
);

    localparam int unsigned TIMER_W = $clog2(TIMEOUT_CYCLES + 1);

    checkout_state_t   state;
    logic [BILL_W-1:0] bill_r;
    logic [2:0]        room_r;
    logic [TIMER_W-1:0] timer;

    logic              code_ok;
    logic              fits;
    logic [BILL_W:0]   sum_wide;
    logic              pay_accept;
    logic              timer_fire;
    logic              change_load;
    logic              refund_load;
    logic              disp_load;
    logic [BILL_W-1:0] disp_amount;
    logic              disp_done;
    logic [3:0]        disp_residue;

    // Note qualification and dispenser load decisions for the current cycle.
    always_comb begin
        code_ok     = (note_value(pay_code) != '0);
        sum_wide    = {1'b0, paid_total} + (BILL_W+1)'(note_value(pay_code));
        fits        = !sum_wide[BILL_W];
        pay_accept  = (state == ST_COLLECT) && pay_valid && !cancel && code_ok && fits;
        timer_fire  = (state == ST_COLLECT) && !cancel && !pay_accept &&
                      (timer == TIMER_W'(TIMEOUT_CYCLES - 1));
        change_load = pay_accept && (sum_wide[BILL_W-1:0] >= bill_r);
        refund_load = (state == ST_COLLECT) && (cancel || timer_fire) && (paid_total != '0);
        disp_load   = change_load || refund_load;
        disp_amount = change_load ? (sum_wide[BILL_W-1:0] - bill_r) : paid_total;
    end

    note_dispenser #(
        .BILL_W (BILL_W)
    ) u_dispenser (
        .clk        (clk),
        .rst        (rst),
        .load       (disp_load),
        .amount     (disp_amount),
        .note_valid (note_valid),
        .note_code  (note_code),
        .done       (disp_done),
        .residue    (disp_residue)
    );

    // Checkout FSM with capture registers, paid accumulator and idle timer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= ST_IDLE;
            bill_r         <= '0;
            room_r         <= 3'd0;
            timer          <= '0;
            busy           <= 1'b0;
            booking_reject <= 1'b0;
            pay_reject     <= 1'b0;
            paid_total     <= '0;
            refund_flag    <= 1'b0;
            receipt_valid  <= 1'b0;
            receipt_room   <= 3'd0;
            change_residue <= 4'd0;
            timeout_err    <= 1'b0;
        end else begin
            booking_reject <= booking_valid && (state != ST_IDLE);
            pay_reject     <= pay_valid && ((state != ST_COLLECT) ||
                                            (!cancel && (!code_ok || !fits)));
            timeout_err    <= timer_fire;
            receipt_valid  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (booking_valid) begin
                        bill_r     <= bill;
                        room_r     <= room_id;
                        paid_total <= '0;
                        timer      <= '0;
                        busy       <= 1'b1;
                        if (bill == '0) begin
                            state          <= ST_RECEIPT;
                            receipt_valid  <= 1'b1;
                            receipt_room   <= room_id;
                            change_residue <= 4'd0;
                        end else begin
                            state <= ST_COLLECT;
                        end
                    end
                end
                ST_COLLECT: begin
                    if (cancel || timer_fire) begin
                        if (paid_total != '0) begin
                            state       <= ST_REFUND;
                            refund_flag <= 1'b1;
                        end else begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end
                    end else if (pay_accept) begin
                        paid_total <= sum_wide[BILL_W-1:0];
                        timer      <= '0;
                        if (change_load) state <= ST_CHANGE;
                    end else begin
                        timer <= timer + TIMER_W'(1);
                    end
                end
                ST_CHANGE: begin
                    if (disp_done) begin
                        state          <= ST_RECEIPT;
                        receipt_valid  <= 1'b1;
                        receipt_room   <= room_r;
                        change_residue <= disp_residue;
                    end
                end
                ST_REFUND: begin
                    if (disp_done) begin
                        state       <= ST_IDLE;
                        refund_flag <= 1'b0;
                        busy        <= 1'b0;
                    end
                end
                ST_RECEIPT: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_booking_checkout.sv
// Directed bench for booking_checkout with hand-computed expectations.
module tb_booking_checkout;

    localparam int unsigned BILL_W = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              booking_valid;
    logic [BILL_W-1:0] bill;
    logic [2:0]        room_id;
    logic              pay_valid;
    logic [2:0]        pay_code;
    logic              cancel;
    logic              busy;
    logic              booking_reject;
    logic              pay_reject;
    logic [BILL_W-1:0] paid_total;
    logic              note_valid;
    logic [2:0]        note_code;
    logic              refund_flag;
    logic              receipt_valid;
    logic [2:0]        receipt_room;
    logic [3:0]        change_residue;
    logic              timeout_err;

    int errors = 0;
    int checks = 0;

    booking_checkout #(
        .BILL_W         (BILL_W),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .booking_valid  (booking_valid),
        .bill           (bill),
        .room_id        (room_id),
        .pay_valid      (pay_valid),
        .pay_code       (pay_code),
        .cancel         (cancel),
        .busy           (busy),
        .booking_reject (booking_reject),
        .pay_reject     (pay_reject),
        .paid_total     (paid_total),
        .note_valid     (note_valid),
        .note_code      (note_code),
        .refund_flag    (refund_flag),
        .receipt_valid  (receipt_valid),
        .receipt_room   (receipt_room),
        .change_residue (change_residue),
        .timeout_err    (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic book(input logic [BILL_W-1:0] b, input logic [2:0] r);
        booking_valid = 1'b1;
        bill          = b;
        room_id       = r;
        tick();
        booking_valid = 1'b0;
    endtask

    task automatic pay(input logic [2:0] code);
        pay_valid = 1'b1;
        pay_code  = code;
        tick();
        pay_valid = 1'b0;
        pay_code  = 3'd0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".busy"},     32'(busy), 0);
        chk({tag, ".paid"},     32'(paid_total), 0);
        chk({tag, ".note"},     32'(note_valid), 0);
        chk({tag, ".code"},     32'(note_code), 0);
        chk({tag, ".refund"},   32'(refund_flag), 0);
        chk({tag, ".receipt"},  32'(receipt_valid), 0);
        chk({tag, ".room"},     32'(receipt_room), 0);
        chk({tag, ".residue"},  32'(change_residue), 0);
        chk({tag, ".timeout"},  32'(timeout_err), 0);
        chk({tag, ".prej"},     32'(pay_reject), 0);
        chk({tag, ".brej"},     32'(booking_reject), 0);
    endtask

    initial begin
        int notes;
        rst = 1'b1;
        booking_valid = 1'b0; bill = '0; room_id = 3'd0;
        pay_valid = 1'b0; pay_code = 3'd0; cancel = 1'b0;
        tick(); tick();
        chk_all_zero("reset");
        rst = 1'b0;
        tick();

        // Pay outside COLLECT is rejected
        pay(3'd1);
        chk("idle_pay.reject", 32'(pay_reject), 1);
        chk("idle_pay.busy", 32'(busy), 0);

        // Zero bill goes straight to receipt
        book(16'd0, 3'd7);
        chk("zero.receipt", 32'(receipt_valid), 1);
        chk("zero.room", 32'(receipt_room), 7);
        tick();
        chk("zero.receipt_drop", 32'(receipt_valid), 0);
        chk("zero.idle", 32'(busy), 0);

        // 1: exact payment 1500
        book(16'd1500, 3'd3);
        chk("t1.busy", 32'(busy), 1);
        pay(3'd6); pay(3'd6); pay(3'd6);
        chk("t1.paid", 32'(paid_total), 1500);
        tick();
        chk("t1.no_note", 32'(note_valid), 0);
        chk("t1.receipt_early", 32'(receipt_valid), 0);
        tick();
        chk("t1.receipt", 32'(receipt_valid), 1);
        chk("t1.room", 32'(receipt_room), 3);
        chk("t1.residue", 32'(change_residue), 0);
        tick();
        chk("t1.receipt_drop", 32'(receipt_valid), 0);
        chk("t1.idle", 32'(busy), 0);

        // 2: bill 1730 paid 2000 -> change 200,50,20
        book(16'd1730, 3'd5);
        pay(3'd6); pay(3'd6); pay(3'd6);
        chk("t2.paid3", 32'(paid_total), 1500);
        pay(3'd6);
        chk("t2.paid4", 32'(paid_total), 2000);
        chk("t2.note0", 32'(note_valid), 0);
        tick();
        chk("t2.n1v", 32'(note_valid), 1); chk("t2.n1c", 32'(note_code), 5);
        tick();
        chk("t2.n2v", 32'(note_valid), 1); chk("t2.n2c", 32'(note_code), 3);
        tick();
        chk("t2.n3v", 32'(note_valid), 1); chk("t2.n3c", 32'(note_code), 2);
        tick();
        chk("t2.n4v", 32'(note_valid), 0);
        tick();
        chk("t2.receipt", 32'(receipt_valid), 1);
        chk("t2.room", 32'(receipt_room), 5);
        chk("t2.residue", 32'(change_residue), 0);
        tick();
        chk("t2.idle", 32'(busy), 0);

        // 3: bill 1005 paid 1020 -> one 10 note, residue 5
        book(16'd1005, 3'd1);
        pay(3'd6); pay(3'd6); pay(3'd2);
        tick();
        chk("t3.n1v", 32'(note_valid), 1); chk("t3.n1c", 32'(note_code), 1);
        tick();
        chk("t3.n2v", 32'(note_valid), 0);
        tick();
        chk("t3.receipt", 32'(receipt_valid), 1);
        chk("t3.room", 32'(receipt_room), 1);
        chk("t3.residue", 32'(change_residue), 5);
        tick();

        // 4: cancel beats same-cycle pay -> refund 200,100
        book(16'd900, 3'd2);
        pay(3'd5); pay(3'd4);
        cancel = 1'b1; pay_valid = 1'b1; pay_code = 3'd6;
        tick();
        cancel = 1'b0; pay_valid = 1'b0; pay_code = 3'd0;
        chk("t4.no_reject", 32'(pay_reject), 0);
        chk("t4.paid", 32'(paid_total), 300);
        chk("t4.flag", 32'(refund_flag), 1);
        tick();
        chk("t4.n1v", 32'(note_valid), 1); chk("t4.n1c", 32'(note_code), 5);
        chk("t4.flag1", 32'(refund_flag), 1);
        tick();
        chk("t4.n2v", 32'(note_valid), 1); chk("t4.n2c", 32'(note_code), 4);
        tick();
        chk("t4.n3v", 32'(note_valid), 0);
        chk("t4.flag3", 32'(refund_flag), 1);
        tick();
        chk("t4.idle", 32'(busy), 0);
        chk("t4.flag_drop", 32'(refund_flag), 0);
        chk("t4.no_receipt", 32'(receipt_valid), 0);

        // 5: timeout after 8 idle cycles, refund one 50
        book(16'd600, 3'd4);
        pay(3'd3);
        for (int i = 1; i <= 7; i++) begin
            tick();
            chk($sformatf("t5.no_to%0d", i), 32'(timeout_err), 0);
        end
        tick();
        chk("t5.timeout", 32'(timeout_err), 1);
        chk("t5.flag", 32'(refund_flag), 1);
        tick();
        chk("t5.to_drop", 32'(timeout_err), 0);
        chk("t5.n1v", 32'(note_valid), 1); chk("t5.n1c", 32'(note_code), 3);
        tick();
        chk("t5.n2v", 32'(note_valid), 0);
        tick();
        chk("t5.idle", 32'(busy), 0);

        // Overflow: 65500 + 100 exceeds 16 bits -> rejected
        book(16'hFFFF, 3'd0);
        for (int i = 0; i < 131; i++) pay(3'd6);
        chk("ovf.paid", 32'(paid_total), 65500);
        pay(3'd4);
        chk("ovf.reject", 32'(pay_reject), 1);
        chk("ovf.paid_hold", 32'(paid_total), 65500);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        notes = 0;
        for (int i = 0; i < 200 && busy; i++) begin
            tick();
            if (note_valid) notes++;
        end
        chk("ovf.drain", 32'(busy), 0);
        chk("ovf.notes", 32'(notes), 131);

        // 6: booking reject, invalid code, reset mid-CHANGE
        book(16'd900, 3'd6);
        book(16'd100, 3'd2);
        chk("t6.brej", 32'(booking_reject), 1);
        chk("t6.busy", 32'(busy), 1);
        tick();
        chk("t6.brej_drop", 32'(booking_reject), 0);
        pay(3'd7);
        chk("t6.prej", 32'(pay_reject), 1);
        chk("t6.paid", 32'(paid_total), 0);
        pay(3'd6); pay(3'd6);
        tick();
        chk("t6.n1v", 32'(note_valid), 1); chk("t6.n1c", 32'(note_code), 4);
        #2 rst = 1'b1;
        #1;
        chk_all_zero("t6.async");
        tick();
        chk_all_zero("t6.rst");
        rst = 1'b0;
        tick();
        chk("t6.post", 32'(busy), 0);
        chk("t6.post_note", 32'(note_valid), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
